// File: rtl/inst_capture_if.sv
// -----------------------------------------------------------------------------
// inst_capture_if
//   Valid/ready token channel between the instruction capture front end and
//   the instruction decoder/executor.
//
//   Signals:
//     inst_vld : a token is pending (driven by the producer)
//     inst_wd  : 8-bit instruction byte, stable while inst_vld is high
//     inst_rdy : consumer accepts the token on a cycle with inst_vld && inst_rdy
//
//   Modports:
//     master : producer side (inst_capture)
//     slave  : consumer side (decoder/executor)
// -----------------------------------------------------------------------------
interface inst_capture_if;
  logic       inst_vld;
  logic [7:0] inst_wd;
  logic       inst_rdy;

  modport master (output inst_vld, output inst_wd, input inst_rdy);
  modport slave  (input inst_vld, input inst_wd, output inst_rdy);
endinterface : inst_capture_if

// File: rtl/inst_capture.sv
// -----------------------------------------------------------------------------
// inst_capture
//   Front end of the lab1 calculator. Synchronises the raw step button and
//   the instruction switches, debounces the button, and on each accepted
//   press latches the switch byte into a single pending token offered over a
//   valid/ready channel. A press that arrives while a token is still pending
//   (and not being accepted on that same edge) is dropped and flagged.
//
//   Parameters:
//     DEBOUNCE_CYCLES : synchronised-stable cycles needed to accept a level
//                       change on btnS (>= 2)
//     CNT_W           : width of the debounce counter
//
//   Ports:
//     clk       : system clock, rising edge
//     rst_n     : asynchronous active-low reset
//     btnS      : raw step button (asynchronous, bouncy)
//     sw        : raw instruction switches (asynchronous)
//     inst      : token channel, master side (inst_vld/inst_wd out, inst_rdy in)
//     ovf       : sticky, a press was dropped because a token was pending
//     press_cnt : count of tokens loaded, wraps 255 -> 0
// -----------------------------------------------------------------------------
module inst_capture #(
  parameter int DEBOUNCE_CYCLES = 100000,
  parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 btnS,
  input  logic [7:0]           sw,
  inst_capture_if.master       inst,
  output logic                 ovf,
  output logic [7:0]           press_cnt
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ARM_HI = 2'd1,
    ST_HELD   = 2'd2,
    ST_ARM_LO = 2'd3
  } deb_state_e;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  // ---------------------------------------------------------------------------
  // Two-flop synchronisers for the button and every switch bit
  // ---------------------------------------------------------------------------
  logic       r_btn_meta;
  logic       r_btn_sync;
  logic [7:0] r_sw_meta;
  logic [7:0] r_sw_sync;

  // NOTE: every clocked process uses non-blocking (<=) assignments so all
  // flops sample pre-edge values; blocking here would collapse the two
  // synchroniser stages into one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_btn_meta <= 1'b0;
      r_btn_sync <= 1'b0;
      r_sw_meta  <= 8'h00;
      r_sw_sync  <= 8'h00;
    end else begin
      r_btn_meta <= btnS;
      r_btn_sync <= r_btn_meta;
      r_sw_meta  <= sw;
      r_sw_sync  <= r_sw_meta;
    end
  end

  // ---------------------------------------------------------------------------
  // Debounce FSM: state register
  // ---------------------------------------------------------------------------
  deb_state_e       r_state;
  deb_state_e       w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             w_capture;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // Debounce FSM: next state, counter and capture pulse
  //   The capture pulse is raised only on the ARM_HI -> HELD transition, so a
  //   held button or a bounce on release (ARM_LO -> HELD) never re-captures.
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: defaults first so every path assigns every output; a missing
    // branch would otherwise infer a latch.
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_capture   = 1'b0;

    unique case (r_state)
      ST_IDLE: begin
        if (r_btn_sync) begin
          w_state_nxt = ST_ARM_HI;
          w_cnt_nxt   = '0;
        end
      end

      ST_ARM_HI: begin
        if (!r_btn_sync) begin
          w_state_nxt = ST_IDLE;
        end else if (r_cnt == CNT_LAST) begin
          w_state_nxt = ST_HELD;
          w_capture   = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end

      ST_HELD: begin
        if (!r_btn_sync) begin
          w_state_nxt = ST_ARM_LO;
          w_cnt_nxt   = '0;
        end
      end

      ST_ARM_LO: begin
        if (r_btn_sync) begin
          w_state_nxt = ST_HELD;
        end else if (r_cnt == CNT_LAST) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end

      default: begin
        w_state_nxt = ST_IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Token register
  //   A capture may load when nothing is pending, or when the pending token is
  //   being accepted on this very edge (back-to-back, no bubble). Otherwise the
  //   press is dropped and the sticky overflow flag is set.
  // ---------------------------------------------------------------------------
  logic       r_inst_vld;
  logic [7:0] r_inst_wd;
  logic       r_ovf;
  logic [7:0] r_press_cnt;
  logic       w_accept;

  assign w_accept = r_inst_vld && inst.inst_rdy;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_inst_vld  <= 1'b0;
      r_inst_wd   <= 8'h00;
      r_ovf       <= 1'b0;
      r_press_cnt <= 8'h00;
    end else if (w_capture) begin
      if (!r_inst_vld || w_accept) begin
        r_inst_vld  <= 1'b1;
        r_inst_wd   <= r_sw_sync;
        r_press_cnt <= r_press_cnt + 8'd1;
      end else begin
        r_ovf <= 1'b1;
      end
    end else if (w_accept) begin
      // inst_wd keeps its last value after the token is consumed
      r_inst_vld <= 1'b0;
    end
  end

  assign inst.inst_vld = r_inst_vld;
  assign inst.inst_wd  = r_inst_wd;
  assign ovf           = r_ovf;
  assign press_cnt     = r_press_cnt;

endmodule : inst_capture
